// File: rtl/alu16_seq_ctrl_if.sv
// Front-end handshake bundle for the 16-bit two-pass ALU sequencer.
//   start/op/a/b/cin : request and operands from the calculator front end
//   busy/done        : sequencer status; done pulses for one cycle per op
//   result/zero/carry_out : 16-bit outcome, valid while done is high
interface alu16_seq_ctrl_if;
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 3;

  logic           start;
  logic [OPW-1:0] op;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [DW-1:0]  result;
  logic           zero;
  logic           carry_out;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, zero, carry_out
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, zero, carry_out
  );
endinterface

// File: rtl/alu16_seq_ctrl.sv
// Runs a 16-bit operation on a shared combinational 8-bit ALU in two passes,
// low byte then high byte, chaining the low-pass carry for add/sub.
//   clk, rst_n           : clock, asynchronous active-low reset
//   fe                   : front-end handshake (start/done) and operands/result
//   o_alu_*_c            : combinational drive to the 8-bit ALU
//   i_alu_result/zero/carry : combinational response from the 8-bit ALU
module alu16_seq_ctrl #(
  parameter logic [2:0] OP_ADD = 3'b011,
  parameter logic [2:0] OP_SUB = 3'b100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu16_seq_ctrl_if.slave        fe,
  output logic [7:0]             o_alu_a_c,
  output logic [7:0]             o_alu_b_c,
  output logic [2:0]             o_alu_cs_c,
  output logic                   o_alu_cin_c,
  input  logic [7:0]             i_alu_result,
  input  logic                   i_alu_zero,
  input  logic                   i_alu_carry
);
  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = 8;
  localparam int unsigned OPW = 3;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_chain;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [OPW-1:0]  r_op;
  logic            r_cin;
  logic            r_lo_zero;
  logic            r_lo_carry;
  logic [DW-1:0]  r_result;
  logic            r_zero;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;

  // A request is only accepted when not mid-operation; start while busy is dropped
  assign w_load  = fe.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_chain = (r_op == OP_ADD) || (r_op == OP_SUB);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_DONE:  w_next = w_load ? S_LO : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU drive from state and latched operands
  always_comb begin
    o_alu_a_c   = '0;
    o_alu_b_c   = '0;
    o_alu_cs_c  = '0;
    o_alu_cin_c = 1'b0;
    case (r_state)
      S_LO: begin
        o_alu_a_c   = r_a[BW-1:0];
        o_alu_b_c   = r_b[BW-1:0];
        o_alu_cs_c  = r_op;
        o_alu_cin_c = r_cin;
      end
      S_HI: begin
        o_alu_a_c   = r_a[DW-1:BW];
        o_alu_b_c   = r_b[DW-1:BW];
        o_alu_cs_c  = r_op;
        o_alu_cin_c = w_chain ? r_lo_carry : r_cin;
      end
      default: ;
    endcase
  end

  // Operand latch; front-end inputs are free to change after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cin <= 1'b0;
    end else if (w_load) begin
      r_a   <= fe.a;
      r_b   <= fe.b;
      r_op  <= fe.op;
      r_cin <= fe.cin;
    end
  end

  // Per-pass capture of ALU outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_lo_zero  <= 1'b0;
      r_lo_carry <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
    end else if (r_state == S_LO) begin
      r_result[BW-1:0] <= i_alu_result;
      r_lo_zero        <= i_alu_zero;
      r_lo_carry       <= i_alu_carry;
    end else if (r_state == S_HI) begin
      r_result[DW-1:BW] <= i_alu_result;
      r_zero            <= r_lo_zero & i_alu_zero;
      r_carry           <= i_alu_carry;
    end
  end

  // Status flags registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_LO) || (w_next == S_HI);
      r_done <= (w_next == S_DONE);
    end
  end

  assign fe.busy      = r_busy;
  assign fe.done      = r_done;
  assign fe.result    = r_result;
  assign fe.zero      = r_zero;
  assign fe.carry_out = r_carry;
endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// Directed bench for alu16_seq_ctrl with a behavioural 8-bit ALU attached.
module tb_alu16_seq_ctrl;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_cs;
  logic       alu_cin, alu_zero, alu_carry;
  logic [8:0] alu_wide;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  alu16_seq_ctrl_if u_if ();

  alu16_seq_ctrl #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fe           (u_if),
    .o_alu_a_c    (alu_a),
    .o_alu_b_c    (alu_b),
    .o_alu_cs_c   (alu_cs),
    .o_alu_cin_c  (alu_cin),
    .i_alu_result (alu_result),
    .i_alu_zero   (alu_zero),
    .i_alu_carry  (alu_carry)
  );

  // Reference 8-bit ALU: AND, add-with-carry, subtract-with-borrow
  always_comb begin
    alu_wide = '0;
    case (alu_cs)
      OP_AND: alu_wide = {1'b0, alu_a & alu_b};
      OP_ADD: alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      OP_SUB: alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
      default: alu_wide = '0;
    endcase
    alu_result = alu_wide[7:0];
    alu_carry  = alu_wide[8];
    alu_zero   = (alu_wide[7:0] == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (u_if.done) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    u_if.start = s;
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    u_if.cin   = c;
  endtask

  // One full op from IDLE; operands are scrambled after acceptance
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic [15:0] exp_res,
                        input logic exp_z, input logic exp_c, input logic exp_hi_cin);
    @(negedge clk);
    drive(1'b1, op, a, b, c);
    @(negedge clk);
    drive(1'b0, 3'b111, 16'hDEAD, 16'hBEEF, ~c);
    check({tag, ".lo_busy"}, 32'(u_if.busy), 32'd1);
    check({tag, ".lo_a"},    32'(alu_a), 32'(a[7:0]));
    check({tag, ".lo_b"},    32'(alu_b), 32'(b[7:0]));
    check({tag, ".lo_cs"},   32'(alu_cs), 32'(op));
    check({tag, ".lo_cin"},  32'(alu_cin), 32'(c));
    @(negedge clk);
    check({tag, ".hi_busy"}, 32'(u_if.busy), 32'd1);
    check({tag, ".hi_a"},    32'(alu_a), 32'(a[15:8]));
    check({tag, ".hi_cin"},  32'(alu_cin), 32'(exp_hi_cin));
    check({tag, ".hi_done"}, 32'(u_if.done), 32'd0);
    @(negedge clk);
    check({tag, ".done"},   32'(u_if.done), 32'd1);
    check({tag, ".busy"},   32'(u_if.busy), 32'd0);
    check({tag, ".result"}, 32'(u_if.result), 32'(exp_res));
    check({tag, ".zero"},   32'(u_if.zero), 32'(exp_z));
    check({tag, ".carry"},  32'(u_if.carry_out), 32'(exp_c));
    check({tag, ".idle_cs"}, 32'(alu_cs), 32'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(u_if.done), 32'd0);
    check({tag, ".hold"},       32'(u_if.result), 32'(exp_res));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
    #12;
    check("rst.busy",   32'(u_if.busy), 32'd0);
    check("rst.done",   32'(u_if.done), 32'd0);
    check("rst.result", 32'(u_if.result), 32'd0);
    check("rst.zero",   32'(u_if.zero), 32'd0);
    check("rst.carry",  32'(u_if.carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_chain", OP_ADD, 16'h12FE, 16'h0003, 1'b0, 16'h1301, 1'b0, 1'b0, 1'b1);
    run_op("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_op("add_cin",   OP_ADD, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", OP_SUB, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    run_op("and_nochain", OP_AND, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b1);

    // start re-pulsed during LO and HI must be ignored
    d0 = n_done;
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, OP_ADD, 16'h0000, 16'h0000, 1'b0);
    check("ign.done",   32'(u_if.done), 32'd1);
    check("ign.result", 32'(u_if.result), 32'h0002);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ign.busy",   32'(u_if.busy), 32'd0);
    check("ign.npulse", 32'(n_done - d0), 32'd1);

    // start held: DONE goes straight to LO, done every 3 cycles
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h0100, 16'h0100, 1'b0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("b2b.done1",   32'(u_if.done), 32'd1);
    check("b2b.result1", 32'(u_if.result), 32'h0200);
    @(negedge clk);
    drive(1'b0, OP_AND, 16'h0000, 16'h0000, 1'b0);
    check("b2b.busy",   32'(u_if.busy), 32'd1);
    check("b2b.gap",    32'(u_if.done), 32'd0);
    @(negedge clk);
    check("b2b.gap2",   32'(u_if.done), 32'd0);
    @(negedge clk);
    check("b2b.done2",   32'(u_if.done), 32'd1);
    check("b2b.result2", 32'(u_if.result), 32'h8000);
    check("b2b.carry2",  32'(u_if.carry_out), 32'd0);

    // async reset while in HI discards the op
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h1111, 16'h1111, 1'b1);
    @(negedge clk);
    drive(1'b0, OP_ADD, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("mid.busy", 32'(u_if.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid.busy0",   32'(u_if.busy), 32'd0);
    check("mid.done0",   32'(u_if.done), 32'd0);
    check("mid.result0", 32'(u_if.result), 32'd0);
    check("mid.zero0",   32'(u_if.zero), 32'd0);
    check("mid.carry0",  32'(u_if.carry_out), 32'd0);
    check("mid.idle_a",  32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
